dm_resp: RTL
============

# dm_resp

Data-memory responder at the far end of the CPU's data-access port. It accepts one load/store request at a time over a valid/ready handshake and holds it for a programmable latency. It then commits the byte, half or word write, or extracts and extends the read data, and returns a response over a second valid/ready handshake. It lets the datapath move from a zero-latency DM to a multi-cycle memory without changing access semantics.

## Interface
- DEPTH_WORDS, 3072, number of 32-bit words in the array (byte address range 0 .. 4*DEPTH_WORDS-1)
- LATENCY, 2, cycles spent in WAIT per access (legal range 1..15)
- clk  in  1  rising-edge clock; the block uses one clock only
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when high together with req_valid
- req_we  in  1  1 = store, 0 = load
- req_op  in  3  access type: 0 word, 1 half signed, 2 half unsigned, 3 byte signed, 4 byte unsigned; 5..7 illegal
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when high together with rsp_valid
- rsp_rdata  out  32  load result, aligned and extended; 0 for stores and errors
- rsp_err  out  1  access was misaligned, out of range or had an illegal op

## Operation
- The block has three states: IDLE, WAIT and RESP.
- **IDLE**
  - req_ready=1.
  - On req_valid the block latches we, op, addr and wdata and moves to WAIT.
  - The wait counter loads LATENCY-1.
- **Error check at acceptance.** The request is flagged as an error if any of these hold:
  - op>4;
  - half access with addr[0]!=0;
  - word access with addr[1:0]!=0;
  - addr[31:2] >= DEPTH_WORDS.
- **WAIT**
  - The counter decrements each cycle.
  - At the edge where the counter equals 0, the access happens and the state moves to RESP.
  - Store without error: only the byte lanes selected by op and addr[1:0] are written.
    - Byte: lane addr[1:0].
    - Half: lanes {addr[1],0} and {addr[1],1}.
    - Word: all four lanes.
  - Load without error: the selected lanes are shifted to bit 0 and sign- or zero-extended per op. The result is registered into rsp_rdata.
  - Error: nothing is written, rsp_rdata=0, rsp_err=1.
- **RESP**
  - rsp_valid=1; rsp_rdata and rsp_err are held stable.
  - On rsp_ready the state returns to IDLE.
  - rsp_valid and rsp_err clear; rsp_rdata clears to 0.
- req_ready is 0 in WAIT and RESP. A request presented in those states waits until IDLE.
- Stores with req_op 1 and 2 are identical, as are stores with req_op 3 and 4.
- **Reset (reset=0)**
  - FSM goes to IDLE; counter 0; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0.
  - All memory words are zeroed.
  - A write in flight in WAIT is discarded.
- Addresses are byte addresses. There is no address translation; the base is 0.

## Timing
- Accept edge is T0. The memory access and the response registering happen at edge T0+LATENCY.
- rsp_valid is high from cycle T0+LATENCY. With rsp_ready already high, the state is back to IDLE after edge T0+LATENCY+1.
- Best-case throughput is one access per LATENCY+2 cycles.
- A load that follows a store to the same address returns the new data; the store has committed before the load is accepted.
- With rsp_ready held low, the block stays in RESP indefinitely with its outputs frozen.
- If reset is asserted in RESP, rsp_valid drops asynchronously without a handshake.

## Structure
- **Shared package dm_pkg:**
  - state enum IDLE/WAIT/RESP;
  - op encoding constants DM_W, DM_H, DM_HU, DM_B, DM_BU;
  - LATENCY width constant (4 bits).
- **Sub-module dm_lane_align (combinational), used for both directions:**
  - store side: op, addr[1:0], wdata → 4-bit byte enable and lane-replicated write word;
  - load side: op, addr[1:0], raw word → extended result.
- The top level holds the FSM, the counter, the request and response registers, and the array.

## Test plan
- Reset, then word store then word load, LATENCY=2.
  - Store 0x12345678 to 0x10.
  - Load from 0x10 → rsp_rdata=0x12345678, rsp_err=0.
  - rsp_valid rises exactly 2 cycles after each accept.
- Byte lanes.
  - Store word 0 to 0x20, then store byte 0x80 to 0x23.
  - LB 0x23 → 0xFFFFFF80.
  - LBU 0x23 → 0x00000080.
  - LW 0x20 → 0x80000000.
- Halves.
  - Store half 0xBEEF to 0x42.
  - LH 0x42 → 0xFFFFBEEF.
  - LHU 0x42 → 0x0000BEEF.
  - LW 0x40 → 0xBEEF0000.
- Errors.
  - SW to 0x13 → rsp_err=1, and a later LW 0x10 is unchanged.
  - LW at 4*DEPTH_WORDS → rsp_err=1, rsp_rdata=0.
  - Access with req_op=6 → rsp_err=1.
- Backpressure.
  - Hold rsp_ready=0 for 5 cycles: rsp_valid stays 1, data is stable, req_ready=0 while a second req_valid is pending.
  - After release, the second request is accepted in the next IDLE cycle.
- Reset mid-operation.
  - Assert reset during WAIT of a SW 0xFFFFFFFF to 0x0 → req_ready=1 and rsp_valid=0 immediately.
  - After release, LW 0x0 → 0x00000000.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder.
//   dm_state_t  : responder FSM states (IDLE / WAIT / RESP)
//   DM_*        : load/store access-type encodings carried on req_op
//   DM_LAT_W    : width of the latency counter (LATENCY range 1..15)
package dm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dm_state_t;

  localparam logic [2:0] DM_W  = 3'd0;  // word
  localparam logic [2:0] DM_H  = 3'd1;  // half, sign-extended on load
  localparam logic [2:0] DM_HU = 3'd2;  // half, zero-extended on load
  localparam logic [2:0] DM_B  = 3'd3;  // byte, sign-extended on load
  localparam logic [2:0] DM_BU = 3'd4;  // byte, zero-extended on load

  localparam int DM_LAT_W = 4;

  // True when the op is illegal or the address is not naturally aligned
  // for the access size. The range check is done by the caller.
  function automatic logic dm_bad_access(input logic [2:0] op, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    if (op > DM_BU) bad = 1'b1;
    else if ((op == DM_H || op == DM_HU) && addr_lo[0]) bad = 1'b1;
    else if (op == DM_W && addr_lo != 2'b00) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Byte-lane steering for one access, purely combinational.
//   i_op, i_addr_lo : access type and byte offset within the word
//   i_wdata         : right-aligned store data
//   i_rword         : raw 32-bit word read from the array
//   o_be            : byte-lane write enables for a store
//   o_wword         : store data replicated onto every candidate lane
//   o_rdata         : load result shifted to bit 0 and sign/zero extended
module dm_lane_align
  import dm_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wword,
  output logic [31:0] o_rdata
);

  logic [31:0] w_shift;

  // Move the addressed lane(s) down to bit 0 before extension.
  assign w_shift = i_rword >> {i_addr_lo, 3'b000};

  always_comb begin
    o_be    = 4'b0000;
    o_wword = i_wdata;
    o_rdata = 32'h0;
    case (i_op)
      DM_W: begin
        o_be    = 4'b1111;
        o_rdata = i_rword;
      end
      DM_H, DM_HU: begin
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wword = {2{i_wdata[15:0]}};
        o_rdata = (i_op == DM_H) ? {{16{w_shift[15]}}, w_shift[15:0]}
                                 : {16'h0, w_shift[15:0]};
      end
      DM_B, DM_BU: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wword = {4{i_wdata[7:0]}};
        o_rdata = (i_op == DM_B) ? {{24{w_shift[7]}}, w_shift[7:0]}
                                 : {24'h0, w_shift[7:0]};
      end
      default: begin
        o_be    = 4'b0000;
        o_rdata = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/dm_resp.sv
// Data-memory responder: accepts one load/store, holds it LATENCY cycles,
// then commits the store or registers the load result and returns it.
//   clk, reset              : clock, asynchronous active-low reset
//   req_valid/req_ready     : request handshake; req_we/op/addr/wdata payload
//   rsp_valid/rsp_ready     : response handshake; rsp_rdata/rsp_err payload
//   o_dbg_state             : current FSM state for observation
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Once raised, rsp_valid and its payload stay constant until that
// transfer. req_ready is high only in IDLE, so at most one access is in flight.
module dm_resp
  import dm_pkg::*;
#(
  parameter int DEPTH_WORDS = 3072,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output dm_state_t   o_dbg_state
);

  localparam int AW = $clog2(DEPTH_WORDS);

  dm_state_t             r_state;
  logic [DM_LAT_W-1:0]   r_cnt;
  logic                  r_req_ready;
  logic                  r_rsp_valid;
  logic [31:0]           r_rsp_rdata;
  logic                  r_rsp_err;
  logic                  r_we;
  logic [2:0]            r_op;
  logic [31:0]           r_addr;
  logic [31:0]           r_wdata;
  logic                  r_err;
  logic [31:0]           r_mem [0:DEPTH_WORDS-1];

  logic                  w_req_err;
  logic                  w_commit;
  logic [AW-1:0]         w_idx;
  logic [31:0]           w_rword;
  logic [3:0]            w_be;
  logic [31:0]           w_wword;
  logic [31:0]           w_ld_data;

  assign w_req_err = dm_bad_access(req_op, req_addr[1:0]) ||
                     (req_addr[31:2] >= 30'(DEPTH_WORDS));

  // The access itself happens on the last WAIT edge.
  assign w_commit = (r_state == ST_WAIT) && (r_cnt == '0);
  assign w_idx    = r_addr[AW+1:2];
  // Errored accesses may carry an index past the array; never read there.
  assign w_rword  = r_err ? 32'h0 : r_mem[w_idx];

  dm_lane_align u_align (
    .i_op      (r_op),
    .i_addr_lo (r_addr[1:0]),
    .i_wdata   (r_wdata),
    .i_rword   (w_rword),
    .o_be      (w_be),
    .o_wword   (w_wword),
    .o_rdata   (w_ld_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
      r_we        <= 1'b0;
      r_op        <= DM_W;
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_we        <= req_we;
            r_op        <= req_op;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_err       <= w_req_err;
            r_cnt       <= DM_LAT_W'(LATENCY - 1);
            r_req_ready <= 1'b0;
            r_state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= r_err;
            r_rsp_rdata <= (r_err || r_we) ? 32'h0 : w_ld_data;
            r_state     <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_req_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  // Array: cleared on reset, which also drops any store still in WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) r_mem[i] <= 32'h0;
    end else if (w_commit && r_we && !r_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
      end
    end
  end

  assign req_ready   = r_req_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign o_dbg_state = r_state;

endmodule
